quad_decoder: RTL

Quadrature incremental-encoder decoder: takes the two asynchronous phase inputs of a rotary/linear encoder and produces one-cycle step strobes with direction, plus a running position count. It is the producing end of the up/down counting interface. Its `enable`/`up_down` outputs connect directly to the enable/direction inputs of the lab up/down counter. The internal `count` mirrors that counter for self-check.

---
 rtl/quad_pkg.sv | 32 +++
 rtl/glitch_filter.sv | 69 ++++++
 rtl/quad_decoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared types and the step classifier for the quadrature decoder.
package quad_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } quad_state_t;

  // Filtered phase pair, {a, b}.
  typedef logic [1:0] quad_phase_t;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } quad_step_t;

  // Classify the move from prev to cur along the Gray cycle 00->01->11->10->00.
  // Any pair not listed has both bits flipping, which cannot be a single step.
  function automatic quad_step_t quad_step(input quad_phase_t prev, input quad_phase_t cur);
    quad_step_t s;
    case ({prev, cur})
      4'b00_00, 4'b01_01, 4'b11_11, 4'b10_10: s = STEP_NONE;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_UP;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_DOWN;
      default:                                s = STEP_ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// Two-flop synchronizer followed by a stability filter for one encoder phase.
// 'filt' follows the synchronized input only after the input has disagreed
// with it for FILTER_CYCLES consecutive clocks. 'valid' rises once the channel
// has been seen stable (either agreeing or disagreeing) for FILTER_CYCLES
// clocks since reset, so the decoder knows its reference phase is trustworthy.
module glitch_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic filt,
  output logic valid
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          diff_prev;
  logic          diff;
  logic [CW-1:0] base;

  // Disagreement with the filtered value; a change in disagreement is a bounce
  // and restarts the run length from zero.
  always_comb begin
    diff = sync2 ^ filt;
    if (diff == diff_prev) begin
      base = cnt;
    end else begin
      base = '0;
    end
  end

  // Metastability guard on the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Run-length counter: accept the synchronized value after a full stable run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      diff_prev <= 1'b0;
      filt      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      diff_prev <= diff;
      if (valid && !diff) begin
        cnt <= '0;
      end else if (base == LAST) begin
        cnt   <= '0;
        filt  <= sync2;
        valid <= 1'b1;
      end else begin
        cnt <= base + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: filters both phases, tracks the Gray sequence
// and emits one-cycle step strobes with direction plus a wrapping position.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             err_clr,
  output logic             enable,
  output logic             up_down,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  logic        filt_a;
  logic        filt_b;
  logic        valid_a;
  logic        valid_b;
  quad_phase_t phase;
  quad_phase_t p_prev;
  quad_state_t state;
  quad_step_t  step;

  glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .clk   (clk),
    .rst   (rst),
    .din   (quad_a),
    .filt  (filt_a),
    .valid (valid_a)
  );

  glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .clk   (clk),
    .rst   (rst),
    .din   (quad_b),
    .filt  (filt_b),
    .valid (valid_b)
  );

  assign phase = {filt_a, filt_b};

  // Classify the move since the last reference phase.
  always_comb begin
    step = quad_step(p_prev, phase);
  end

  // INIT/TRACK state machine with registered strobe, direction, count and error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      p_prev  <= 2'b00;
      enable  <= 1'b0;
      up_down <= 1'b1;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      enable <= 1'b0;
      // Clear first so that an illegal step in the same cycle overrides it.
      if (err_clr) begin
        err <= 1'b0;
      end
      case (state)
        INIT: begin
          // The phase present at start-up becomes the reference, never a step.
          if (valid_a && valid_b) begin
            p_prev <= phase;
            state  <= TRACK;
          end
        end
        TRACK: begin
          p_prev <= phase;
          case (step)
            STEP_UP: begin
              enable  <= 1'b1;
              up_down <= 1'b1;
              count   <= count + CNT_W'(1);
            end
            STEP_DOWN: begin
              enable  <= 1'b1;
              up_down <= 1'b0;
              count   <= count - CNT_W'(1);
            end
            STEP_ILLEGAL: begin
              err <= 1'b1;
            end
            STEP_NONE: begin
              enable <= 1'b0;
            end
            default: begin
              enable <= 1'b0;
            end
          endcase
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule
